// File: rtl/alu_pkg.sv
// Shared definitions for the ALU branch path: branch opcodes, FSM states
// and the default flush length.
package alu_pkg;

    typedef enum logic [1:0] {
        BR_BNE  = 2'b00,
        BR_BLT  = 2'b01,
        BR_J    = 2'b10,
        BR_RSVD = 2'b11
    } br_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_t;

    localparam int FLUSH_CYCLES_DEFAULT = 2;

    // Taken decision for one branch. The flag that does not belong to the
    // opcode is ignored, so the comparator may present anything on it.
    function automatic logic br_taken(input br_op_t op,
                                      input logic   not_equal,
                                      input logic   less_than);
        logic t;
        case (op)
            BR_BNE:  t = not_equal;
            BR_BLT:  t = less_than;
            BR_J:    t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Redirect target computation: pc + 1 + imm for conditional branches,
// pc[31:27] spliced with imm[26:0] for jumps. Purely combinational.
module branch_target_adder
    import alu_pkg::*;
(
    input  logic [1:0]  br_op,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] target
);

    logic [31:0] rel_target;
    logic [31:0] abs_target;

    // Carry out of the add is dropped: targets wrap modulo 2^32.
    assign rel_target = pc + 32'd1 + imm;
    assign abs_target = {pc[31:27], imm[26:0]};

    // Select the target form matching the opcode.
    always_comb begin
        target = rel_target;
        if (br_op_t'(br_op) == BR_J) begin
            target = abs_target;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: decides taken/not-taken from the comparator
// flags, issues a one-cycle redirect, holds a multi-cycle flush while
// refusing new branches, and counts taken branches (saturating).
module branch_resolve
    import alu_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       br_op,
    input  logic             is_not_equal,
    input  logic             is_less_than,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    // Flush counter preload: the first flush cycle is the one after accept.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    br_state_t          state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic               rv_next;
    logic [31:0]        rpc_next;
    logic               flush_next;
    logic [CNT_W-1:0]   tc_next;
    logic [31:0]        target;
    logic               accept;
    logic               taken;

    // Counter increments stick at all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    branch_target_adder u_target (
        .br_op  (br_op),
        .pc     (pc),
        .imm    (imm),
        .target (target)
    );

    // Ready depends only on state and reset, never on in_valid.
    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign taken    = br_taken(br_op_t'(br_op), is_not_equal, is_less_than);

    // Next-state and next-output decode for the resolve FSM.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rv_next    = 1'b0;
        rpc_next   = redirect_pc;
        flush_next = flush;
        tc_next    = taken_count;
        case (state)
            IDLE: begin
                if (accept && taken) begin
                    rv_next    = 1'b1;
                    rpc_next   = target;
                    flush_next = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = FLUSH;
                    tc_next    = sat_inc(taken_count);
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) begin
                    flush_next = 1'b0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                flush_next = 1'b0;
            end
        endcase
    end

    // State, flush counter and output registers; reset clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush          <= 1'b0;
            taken_count    <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            redirect_valid <= rv_next;
            redirect_pc    <= rpc_next;
            flush          <= flush_next;
            taken_count    <= tc_next;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve. A second instance with a 4-bit taken
// counter shares all inputs so counter saturation can be observed.
module tb_branch_resolve;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  br_op;
    logic        is_not_equal;
    logic        is_less_than;
    logic [31:0] pc;
    logic [31:0] imm;

    logic        in_ready, redirect_valid, flush;
    logic [31:0] redirect_pc;
    logic [15:0] taken_count;

    logic        in_ready_s, redirect_valid_s, flush_s;
    logic [31:0] redirect_pc_s;
    logic [3:0]  taken_count_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .br_op          (br_op),
        .is_not_equal   (is_not_equal),
        .is_less_than   (is_less_than),
        .pc             (pc),
        .imm            (imm),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .taken_count    (taken_count)
    );

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_small (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready_s),
        .br_op          (br_op),
        .is_not_equal   (is_not_equal),
        .is_less_than   (is_less_than),
        .pc             (pc),
        .imm            (imm),
        .redirect_valid (redirect_valid_s),
        .redirect_pc    (redirect_pc_s),
        .flush          (flush_s),
        .taken_count    (taken_count_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic ne,
                         input logic lt, input logic [31:0] p, input logic [31:0] i);
        in_valid     = v;
        br_op        = op;
        is_not_equal = ne;
        is_less_than = lt;
        pc           = p;
        imm          = i;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_rv",    64'(redirect_valid), 64'd0);
        chk("rst_rpc",   64'(redirect_pc),    64'd0);
        chk("rst_flush", 64'(flush),          64'd0);
        chk("rst_tc",    64'(taken_count),    64'd0);
        chk("rst_ready", 64'(in_ready),       64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // BNE taken: 0x100 + 1 + 0x10 = 0x111
        drive(1'b1, 2'b00, 1'b1, 1'b0, 32'h100, 32'h10);
        tick();
        in_valid = 1'b0;
        chk("bne_rv",     64'(redirect_valid), 64'd1);
        chk("bne_rpc",    64'(redirect_pc),    64'h111);
        chk("bne_flush1", 64'(flush),          64'd1);
        chk("bne_ready1", 64'(in_ready),       64'd0);
        chk("bne_tc",     64'(taken_count),    64'd1);
        tick();
        chk("bne_rv_pulse", 64'(redirect_valid), 64'd0);
        chk("bne_flush2",   64'(flush),          64'd1);
        chk("bne_ready2",   64'(in_ready),       64'd0);
        chk("bne_rpc_hold", 64'(redirect_pc),    64'h111);
        tick();
        chk("bne_flush_end", 64'(flush),    64'd0);
        chk("bne_ready_end", 64'(in_ready), 64'd1);

        // Four back-to-back not-taken BNEs
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h200 + 32'(k), 32'h40);
            chk("nt_ready", 64'(in_ready), 64'd1);
            tick();
            chk("nt_rv",    64'(redirect_valid), 64'd0);
            chk("nt_flush", 64'(flush),          64'd0);
        end
        in_valid = 1'b0;
        chk("nt_tc",  64'(taken_count), 64'd1);
        chk("nt_rpc", 64'(redirect_pc), 64'h111);

        // BLT with is_less_than=0 but is_not_equal=1 is not taken
        drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h300, 32'h5);
        tick();
        in_valid = 1'b0;
        chk("blt_nt_rv", 64'(redirect_valid), 64'd0);

        // BLT wrap: 0xFFFFFFFF + 1 + 0 = 0
        drive(1'b1, 2'b01, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("blt_wrap_rv",  64'(redirect_valid), 64'd1);
        chk("blt_wrap_rpc", 64'(redirect_pc),    64'h0);
        chk("blt_wrap_tc",  64'(taken_count),    64'd2);
        tick();
        tick();
        chk("blt_wrap_ready", 64'(in_ready), 64'd1);

        // BLT negative offset: 0x20 + 1 - 2 = 0x1F
        drive(1'b1, 2'b01, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFE);
        tick();
        in_valid = 1'b0;
        chk("blt_neg_rpc", 64'(redirect_pc), 64'h1F);
        chk("blt_neg_tc",  64'(taken_count), 64'd3);
        tick();
        tick();

        // J with in_valid held through the flush
        drive(1'b1, 2'b10, 1'b0, 1'b0, 32'hA800_0004, 32'h0000_0123);
        tick();
        chk("j_rpc",   64'(redirect_pc), 64'hA800_0123);
        chk("j_tc",    64'(taken_count), 64'd4);
        chk("j_ready", 64'(in_ready),    64'd0);
        drive(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk("hold_rv1",    64'(redirect_valid), 64'd0);
        chk("hold_rpc1",   64'(redirect_pc),    64'hA800_0123);
        tick();
        chk("hold_rv2",    64'(redirect_valid), 64'd0);
        chk("hold_ready",  64'(in_ready),       64'd1);
        chk("hold_tc",     64'(taken_count),    64'd4);
        tick();
        in_valid = 1'b0;
        chk("held_rv",  64'(redirect_valid), 64'd1);
        chk("held_rpc", 64'(redirect_pc),    64'h1);
        chk("held_tc",  64'(taken_count),    64'd5);

        // Reset during the second flush cycle
        tick();
        chk("mid_flush", 64'(flush), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_gates_ready", 64'(in_ready), 64'd0);
        tick();
        chk("mrst_flush", 64'(flush),          64'd0);
        chk("mrst_rv",    64'(redirect_valid), 64'd0);
        chk("mrst_rpc",   64'(redirect_pc),    64'd0);
        chk("mrst_tc",    64'(taken_count),    64'd0);
        reset = 1'b0;
        #1;
        chk("mrst_ready", 64'(in_ready), 64'd1);

        // Reserved opcode with both flags set is never taken
        drive(1'b1, 2'b11, 1'b1, 1'b1, 32'h40, 32'h4);
        tick();
        in_valid = 1'b0;
        chk("rsvd_rv",    64'(redirect_valid), 64'd0);
        chk("rsvd_flush", 64'(flush),          64'd0);
        chk("rsvd_tc",    64'(taken_count),    64'd0);
        chk("rsvd_ready", 64'(in_ready),       64'd1);

        // 17 taken jumps: 16-bit counter reaches 17, 4-bit sticks at 15
        for (int k = 1; k <= 17; k++) begin
            drive(1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'(k));
            tick();
            in_valid = 1'b0;
            chk("sat_rv",       64'(redirect_valid_s), 64'd1);
            chk("sat_tc_wide",  64'(taken_count),      64'(k));
            chk("sat_tc_small", 64'(taken_count_s),    64'((k > 15) ? 15 : k));
            tick();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
